// File: rtl/xalu_ise_pkg.sv
// Shared types and constants for the custom-instruction ALU issue port.
// Imported by the issue controller, its timeout counter and the bench.
package xalu_ise_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        RESP = ST_RESP
    } ise_state_e;

    localparam logic [1:0] CUSTOM_0 = 2'b00;
    localparam logic [1:0] CUSTOM_1 = 2'b01;
    localparam logic [1:0] CUSTOM_2 = 2'b10;
    localparam logic [1:0] CUSTOM_3 = 2'b11;

    localparam logic [3:0] FN_CSIDH_ANDADD = 4'b0111;
    localparam logic [3:0] FN_CSIDH_SUB    = 4'b0011;

    // The ALU function code carries the custom-N index in its low bits.
    function automatic logic [5:0] ise_fn_encode(input logic [1:0] opcode);
        return {4'b0000, opcode};
    endfunction

endpackage

// File: rtl/xalu_ise_tmo.sv
// Saturating 8-bit BUSY-cycle counter; hit_o flags the last permitted
// cycle before an unanswered request is declared illegal.
module xalu_ise_tmo #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [7:0] HIT_VAL = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == HIT_VAL);

endmodule

// File: rtl/xalu_ise_issue.sv
// Issue/collect controller: one custom instruction in flight, request bus held
// until the ALU answers or the timeout expires, result handed to writeback.
module xalu_ise_issue
    import xalu_ise_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic             ise_clk,
    input  logic             ise_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_opcode,
    input  logic [6:0]       req_funct7,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_rd,
    output logic [5:0]       ise_fn,
    output logic [6:0]       ise_imm,
    output logic [XLEN-1:0]  ise_in1,
    output logic [XLEN-1:0]  ise_in2,
    output logic             ise_val,
    input  logic             ise_oval,
    input  logic [XLEN-1:0]  ise_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_rd,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_illegal
);

    ise_state_e state_q;
    ise_state_e state_d;

    logic [1:0]       opcode_q;
    logic [6:0]       funct7_q;
    logic [XLEN-1:0]  in1_q;
    logic [XLEN-1:0]  in2_q;
    logic [TAG_W-1:0] rd_q;

    logic [XLEN-1:0]  rsp_data_q;
    logic [XLEN-1:0]  rsp_data_d;
    logic             rsp_ill_q;
    logic             rsp_ill_d;
    logic [TAG_W-1:0] rsp_rd_q;
    logic [TAG_W-1:0] rsp_rd_d;

    logic busy;
    logic resp;
    logic accept;
    logic tmo_hit;

    assign busy = (state_q == BUSY);
    assign resp = (state_q == RESP);

    // A response hand-off frees the slot in the same cycle, enabling back-to-back issue.
    assign req_ready = !ise_rst && ((state_q == IDLE) || (resp && rsp_ready));
    assign accept    = req_valid && req_ready;

    xalu_ise_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i (ise_clk),
        .rst_i (ise_rst),
        .clr_i (accept),
        .en_i  (busy && !ise_oval),
        .hit_o (tmo_hit)
    );

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_ill_d  = rsp_ill_q;
        rsp_rd_d   = rsp_rd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ise_oval) begin
                    state_d    = RESP;
                    rsp_data_d = ise_out;
                    rsp_ill_d  = 1'b0;
                    rsp_rd_d   = rd_q;
                end else if (tmo_hit) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                    rsp_ill_d  = 1'b1;
                    rsp_rd_d   = rd_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = accept ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_ill_q  <= 1'b0;
            rsp_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_ill_q  <= rsp_ill_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    // Request bus registers change only on an accepted request.
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            opcode_q <= '0;
            funct7_q <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            opcode_q <= req_opcode;
            funct7_q <= req_funct7;
            in1_q    <= req_rs1;
            in2_q    <= req_rs2;
            rd_q     <= req_rd;
        end
    end

    assign ise_fn      = ise_fn_encode(opcode_q);
    assign ise_imm     = funct7_q;
    assign ise_in1     = in1_q;
    assign ise_in2     = in2_q;
    assign ise_val     = busy;

    assign rsp_valid   = resp;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_illegal = rsp_ill_q;

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Directed bench for xalu_ise_issue: a transaction-level reference model checked
// every cycle, plus hand-computed latency/data expectations per scenario.
module tb_xalu_ise_issue;
    import xalu_ise_pkg::*;

    localparam int XL  = 64;
    localparam int TW  = 5;
    localparam int TMO = 4;

    localparam int M_MISS = 0;
    localparam int M_HIT  = 1;
    localparam int M_DLY  = 2;
    localparam int M_ALW  = 3;

    logic          ise_clk = 1'b0;
    logic          ise_rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_opcode = '0;
    logic [6:0]    req_funct7 = '0;
    logic [XL-1:0] req_rs1 = '0;
    logic [XL-1:0] req_rs2 = '0;
    logic [TW-1:0] req_rd = '0;
    logic [5:0]    ise_fn;
    logic [6:0]    ise_imm;
    logic [XL-1:0] ise_in1;
    logic [XL-1:0] ise_in2;
    logic          ise_val;
    logic          ise_oval;
    logic [XL-1:0] ise_out;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_rd;
    logic [XL-1:0] rsp_data;
    logic          rsp_illegal;

    int            checks = 0;
    int            failures = 0;

    // ALU stand-in
    int            alu_mode = M_MISS;
    logic          use_sum = 1'b0;
    logic [XL-1:0] alu_fixed = '0;
    int            val_age = 0;

    assign ise_oval = (alu_mode == M_ALW) ? 1'b1 :
                      (alu_mode == M_HIT) ? ise_val :
                      (alu_mode == M_DLY) ? (ise_val && (val_age == 3)) : 1'b0;
    assign ise_out  = use_sum ? (ise_in1 + ise_in2) : alu_fixed;

    always @(posedge ise_clk) val_age <= ise_val ? val_age + 1 : 0;

    always #5 ise_clk = ~ise_clk;

    xalu_ise_issue #(
        .XLEN    (XL),
        .TAG_W   (TW),
        .TIMEOUT (TMO)
    ) dut (
        .ise_clk     (ise_clk),
        .ise_rst     (ise_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_funct7  (req_funct7),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .ise_fn      (ise_fn),
        .ise_imm     (ise_imm),
        .ise_in1     (ise_in1),
        .ise_in2     (ise_in2),
        .ise_val     (ise_val),
        .ise_oval    (ise_oval),
        .ise_out     (ise_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rd      (rsp_rd),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what is in flight and what response is waiting.
    bit            mon_on = 1'b0;
    bit            m_inflight = 1'b0;
    int            m_age = 0;
    logic [1:0]    m_op = '0;
    logic [6:0]    m_f7 = '0;
    logic [XL-1:0] m_rs1 = '0;
    logic [XL-1:0] m_rs2 = '0;
    logic [TW-1:0] m_rd = '0;
    bit            m_pend = 1'b0;
    logic [TW-1:0] m_rrd = '0;
    logic [XL-1:0] m_rdata = '0;
    logic          m_rill = 1'b0;
    int            cyc = 0;
    logic [TW-1:0] ho_rd[$];
    int            ho_cyc[$];

    always @(negedge ise_clk) begin
        bit e_rr;
        bit acc;
        bit done;
        e_rr = !ise_rst && !m_inflight && (!m_pend || rsp_ready);
        if (mon_on) begin
            chk("req_ready", 64'(req_ready), 64'(e_rr));
            chk("ise_val", 64'(ise_val), 64'(m_inflight));
            chk("ise_fn", 64'(ise_fn), {62'd0, m_op});
            chk("ise_imm", 64'(ise_imm), 64'(m_f7));
            chk("ise_in1", ise_in1, m_rs1);
            chk("ise_in2", ise_in2, m_rs2);
            chk("rsp_valid", 64'(rsp_valid), 64'(m_pend));
            chk("rsp_rd", 64'(rsp_rd), 64'(m_rrd));
            chk("rsp_data", rsp_data, m_rdata);
            chk("rsp_illegal", 64'(rsp_illegal), 64'(m_rill));
            if (!ise_rst && rsp_valid && rsp_ready) begin
                ho_rd.push_back(rsp_rd);
                ho_cyc.push_back(cyc);
            end
        end
        if (ise_rst) begin
            m_inflight = 1'b0; m_age = 0; m_op = '0; m_f7 = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_pend = 1'b0; m_rrd = '0; m_rdata = '0; m_rill = 1'b0;
        end else begin
            acc  = req_valid && e_rr;
            done = m_pend && rsp_ready;
            if (done) m_pend = 1'b0;
            if (m_inflight) begin
                if (ise_oval) begin
                    m_inflight = 1'b0; m_pend = 1'b1; m_rrd = m_rd; m_rill = 1'b0;
                    m_rdata = use_sum ? (m_rs1 + m_rs2) : alu_fixed;
                end else if (m_age + 1 >= TMO) begin
                    m_inflight = 1'b0; m_pend = 1'b1; m_rrd = m_rd; m_rill = 1'b1;
                    m_rdata = '0;
                end else begin
                    m_age++;
                end
            end
            if (acc) begin
                m_inflight = 1'b1; m_age = 0;
                m_op = req_opcode; m_f7 = req_funct7;
                m_rs1 = req_rs1; m_rs2 = req_rs2; m_rd = req_rd;
            end
        end
        cyc++;
    end

    // Called just after a posedge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [6:0] f7,
                         input logic [XL-1:0] a, input logic [XL-1:0] b,
                         input logic [TW-1:0] rd);
        bit ok;
        ok = 1'b0;
        req_opcode = op; req_funct7 = f7; req_rs1 = a; req_rs2 = b; req_rd = rd;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ise_clk);
            if (req_ready) ok = 1'b1;
            else begin
                @(posedge ise_clk); #1;
            end
        end
        @(posedge ise_clk); #1;
        req_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL issue_wait: req_ready never high for tag %0d", rd);
        end
    endtask

    task automatic wait_rsp(input int maxc, output int lat);
        lat = 0;
        do begin
            @(negedge ise_clk);
            lat++;
        end while (!rsp_valid && lat < maxc);
        if (!rsp_valid) lat = -1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge ise_clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nval;
        int cnt;
        logic [XL-1:0] opa;
        logic [XL-1:0] opb;

        @(posedge ise_clk);
        mon_on = 1'b1;
        @(posedge ise_clk); #1;
        ise_rst = 1'b0;

        // Reset state
        @(negedge ise_clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_ise_val", 64'(ise_val), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_ise_in1", ise_in1, 64'd0);
        chk("rst_ise_fn", 64'(ise_fn), 64'd0);
        @(posedge ise_clk); #1;

        // Legal hit
        alu_mode = M_HIT; use_sum = 1'b0; alu_fixed = 64'hDEAD_BEEF; rsp_ready = 1'b0;
        ho_rd.delete(); ho_cyc.delete();
        issue(CUSTOM_0, 7'h07, 64'hFFFF_0000_FFFF_0000, 64'h1, 5'd3);
        wait_rsp(12, lat);
        chk("hit_latency", 64'(lat), 64'd2);
        chk("hit_data", rsp_data, 64'hDEAD_BEEF);
        chk("hit_illegal", 64'(rsp_illegal), 64'd0);
        chk("hit_rd", 64'(rsp_rd), 64'd3);

        // Backpressure with a competing request offered
        @(posedge ise_clk); #1;
        alu_fixed = 64'h0BAD_F00D;
        req_opcode = CUSTOM_1; req_funct7 = {3'b000, FN_CSIDH_ANDADD};
        req_rs1 = 64'h10; req_rs2 = 64'h20; req_rd = 5'd4; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ise_clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data", rsp_data, 64'hDEAD_BEEF);
            chk("bp_rsp_rd", 64'(rsp_rd), 64'd3);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_ise_val", 64'(ise_val), 64'd0);
            @(posedge ise_clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge ise_clk);
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        @(posedge ise_clk); #1;
        req_valid = 1'b0;
        wait_rsp(12, lat);
        chk("bp_next_latency", 64'(lat), 64'd2);
        chk("bp_next_data", rsp_data, 64'h0BAD_F00D);
        chk("bp_next_rd", 64'(rsp_rd), 64'd4);
        drain();
        cnt = 0;
        foreach (ho_rd[i]) if (ho_rd[i] == 5'd3) cnt++;
        chk("bp_single_handoff", 64'(cnt), 64'd1);

        // Miss / timeout
        alu_mode = M_MISS; rsp_ready = 1'b0;
        issue(CUSTOM_0, 7'h05, 64'h55, 64'hAA, 5'd7);
        nval = 0; lat = 0;
        do begin
            @(negedge ise_clk);
            lat++;
            if (ise_val) nval++;
        end while (!rsp_valid && lat < 20);
        chk("miss_latency", 64'(lat), 64'd5);
        chk("miss_busy_cycles", 64'(nval), 64'd4);
        chk("miss_illegal", 64'(rsp_illegal), 64'd1);
        chk("miss_data", rsp_data, 64'd0);
        chk("miss_rd", 64'(rsp_rd), 64'd7);
        drain();

        // ALU answers on the last permitted BUSY cycle
        alu_mode = M_DLY; alu_fixed = 64'h1234_5678_9ABC_DEF0; rsp_ready = 1'b0;
        opa = 64'hA5A5_0000_1111_2222; opb = 64'h0F0F_3333_4444_5555;
        issue(CUSTOM_2, {3'b000, FN_CSIDH_SUB}, opa, opb, 5'd9);
        lat = 0;
        do begin
            @(negedge ise_clk);
            lat++;
            if (ise_val) begin
                chk("dly_in1_stable", ise_in1, opa);
                chk("dly_in2_stable", ise_in2, opb);
                chk("dly_imm_stable", 64'(ise_imm), 64'h03);
            end
        end while (!rsp_valid && lat < 20);
        chk("dly_latency", 64'(lat), 64'd5);
        chk("dly_illegal", 64'(rsp_illegal), 64'd0);
        chk("dly_data", rsp_data, 64'h1234_5678_9ABC_DEF0);
        drain();

        // ise_oval while idle must be ignored
        alu_mode = M_ALW; alu_fixed = 64'hCAFE; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ise_clk);
            chk("alw_idle_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        @(posedge ise_clk); #1;
        issue(CUSTOM_3, 7'h7F, 64'h1, 64'h2, 5'd12);
        wait_rsp(12, lat);
        chk("alw_latency", 64'(lat), 64'd2);
        chk("alw_data", rsp_data, 64'hCAFE);
        chk("alw_fn", 64'(ise_fn), 64'h03);
        drain();

        // Back-to-back
        alu_mode = M_HIT; use_sum = 1'b1; rsp_ready = 1'b1;
        ho_rd.delete(); ho_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            bit ok;
            ok = 1'b0;
            req_opcode = 2'(i); req_funct7 = 7'(i + 1);
            req_rs1 = 64'(100 * i + 1); req_rs2 = 64'(7 * i); req_rd = 5'(16 + i);
            req_valid = 1'b1;
            for (int k = 0; k < 10 && !ok; k++) begin
                @(negedge ise_clk);
                ok = req_ready;
                @(posedge ise_clk); #1;
            end
        end
        req_valid = 1'b0;
        repeat (6) begin
            @(posedge ise_clk); #1;
        end
        chk("b2b_count", 64'(ho_rd.size()), 64'd4);
        if (ho_rd.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("b2b_tag_order", 64'(ho_rd[i]), 64'(16 + i));
            for (int i = 0; i < 3; i++) chk("b2b_spacing", 64'(ho_cyc[i + 1] - ho_cyc[i]), 64'd2);
        end
        use_sum = 1'b0;

        // Reset during BUSY
        alu_mode = M_MISS; rsp_ready = 1'b1;
        issue(CUSTOM_1, 7'h11, 64'h77, 64'h88, 5'd21);
        ise_rst = 1'b1;
        @(negedge ise_clk);
        chk("rstb_ready_in_rst", 64'(req_ready), 64'd0);
        chk("rstb_busy_before", 64'(ise_val), 64'd1);
        @(posedge ise_clk); #1;
        ise_rst = 1'b0;
        ho_rd.delete(); ho_cyc.delete();
        @(negedge ise_clk);
        chk("rstb_ise_val", 64'(ise_val), 64'd0);
        chk("rstb_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstb_req_ready", 64'(req_ready), 64'd1);
        cnt = 0;
        repeat (8) begin
            @(negedge ise_clk);
            if (rsp_valid) cnt++;
        end
        chk("rstb_no_response", 64'(cnt), 64'd0);
        chk("rstb_no_handoff", 64'(ho_rd.size()), 64'd0);

        @(posedge ise_clk); #1;
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xalu_ise_issue.md
# xalu_ise_issue

Core-side issue/collect controller for the custom-instruction ALU port. It accepts decoded custom-0..3 instructions from the execute stage through a valid/ready handshake. It registers and drives the `ise_*` request bus, holds it stable until the ALU raises `ise_oval` or a timeout expires, then presents the result, or an illegal-instruction flag, to writeback through a second valid/ready handshake. One instruction is in flight at a time, and back-to-back issue is allowed on response hand-off.

## Interface
Parameters:
- `XLEN`, 64, operand/result width.
- `TAG_W`, 5, destination-register tag width.
- `TIMEOUT`, 4, max cycles in BUSY without `ise_oval` before flagging illegal; must be ≥1, ≤255.

Ports:
- `ise_clk` in 1: single clock; all state changes on rising edge.
- `ise_rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute stage offers an instruction.
- `req_ready` out 1: controller accepts this cycle.
- `req_opcode` in 2: custom-N index (00=custom-0 … 11=custom-3).
- `req_funct7` in 7: funct7 field, forwarded as `ise_imm`.
- `req_rs1` / `req_rs2` in XLEN: operand values.
- `req_rd` in TAG_W: destination tag.
- `ise_fn` out 6: `{4'b0000, opcode_q}`.
- `ise_imm` out 7: registered funct7.
- `ise_in1` / `ise_in2` out XLEN: registered operands.
- `ise_val` out 1: request valid.
- `ise_oval` in 1: ALU result valid; may be combinational from `ise_val`.
- `ise_out` in XLEN: ALU result.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: writeback accepts.
- `rsp_rd` out TAG_W: tag of completed instruction.
- `rsp_data` out XLEN: result; 0 when illegal.
- `rsp_illegal` out 1: no unit claimed the instruction.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture opcode/funct7/rs1/rs2/rd, clear the timeout counter, and go to BUSY.
- BUSY: `ise_val`=1 and the request bus is held constant.
  - If `ise_oval`=1, capture `ise_out` into `rsp_data`, set `rsp_illegal`=0, and go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1, set `rsp_data`=0 and `rsp_illegal`=1, and go to RESP.
  - Otherwise, increment the counter.
  - `ise_oval` is ignored whenever `ise_val`=0.
- RESP: `rsp_valid`=1, and `rsp_rd`/`rsp_data`/`rsp_illegal` are held until `rsp_ready`.
  - `req_ready` = `rsp_ready`.
  - If `rsp_ready` and `req_valid` are both high, capture the new request and go directly to BUSY.
  - If `rsp_ready` is high without a new request, go to IDLE.
- Operand registers update only on an accepted request. `ise_in*` keep their last value in IDLE but `ise_val`=0.
- The counter is 8 bits and saturates. It never wraps because TIMEOUT ≤ 255.

## Timing
- Reset values: state=IDLE; `ise_val`=0; `rsp_valid`=0; `rsp_illegal`=0; `rsp_data`=0; `rsp_rd`=0; `ise_fn`/`ise_imm`/`ise_in1`/`ise_in2`=0.
- `req_ready`=0 while `ise_rst`=1.
- If a request is accepted at edge T:
  - `ise_val`=1 during cycle T+1.
  - With a combinational ALU hit, `rsp_valid`=1 in cycle T+2, giving latency 2.
- Illegal path: BUSY for exactly TIMEOUT cycles, so `rsp_valid` in cycle T+1+TIMEOUT.
- Throughput: with `rsp_ready` held high and a combinational ALU, one instruction per 2 cycles.
- Reset asserted in BUSY or RESP: the in-flight instruction is discarded with no response, and the next cycle has `ise_val`=0 and `rsp_valid`=0.
- A single-cycle reset pulse is sufficient.
- The `req_valid` and `rsp_ready` inputs are not required to be held; an unaccepted request can be withdrawn.

## Structure
- Package `xalu_ise_pkg` holds:
  - the state enum;
  - `CUSTOM_0..3` = 2'b00..2'b11;
  - funct nibbles `FN_CSIDH_ANDADD`=4'b0111 and `FN_CSIDH_SUB`=4'b0011, for the bench and decode helpers.
- Sub-module `xalu_ise_tmo` holds the 8-bit saturating timeout counter with clear/enable and a `hit` output at TIMEOUT-1.
- The rest is a single flat FSM.
- Target size is ~180 lines of RTL.

## Test plan
- **Legal hit:** opcode=00, funct7=7'h07, rs1=64'hFFFF_0000_FFFF_0000, rs2=64'h1, ALU model returns 64'hDEAD_BEEF with `ise_oval` the same cycle.
  - Expect `rsp_valid` at T+2, `rsp_data`=64'hDEAD_BEEF, `rsp_illegal`=0, and `rsp_rd` equal to the issued tag.
- **Miss:** funct7=7'h05, opcode=00, TIMEOUT=4, ALU never asserts `ise_oval`.
  - Expect `ise_val` high T+1..T+4, `rsp_valid` at T+5, `rsp_illegal`=1, `rsp_data`=0.
- **Backpressure:** hold `rsp_ready`=0 for 3 cycles.
  - Expect the `rsp_*` outputs stable, `req_ready`=0, and `ise_val`=0 throughout.
  - Expect a single hand-off when `rsp_ready` rises.
- **Back-to-back:** `req_valid` and `rsp_ready` held high with 4 tagged requests.
  - Expect 4 responses, in order with matching tags, one every 2 cycles.
- **Delayed ALU:** `ise_oval` asserted 3 cycles after `ise_val`, with TIMEOUT=4.
  - Expect a legal response, and `ise_in*` stable throughout BUSY.
- **Reset mid-BUSY:** pulse `ise_rst` at T+1.
  - Expect `ise_val`=0 and `rsp_valid`=0 at T+2, no response ever emitted for that instruction, and `req_ready`=1 at T+2.
